// File: rtl/load_store_unit.sv
// load_store_unit: memory stage with byte/half/word loads and stores, fault detection and LAT-cycle latency.
// Optional LSU_PERF_CNT_EN adds saturating load/store/fault event counters.
module load_store_unit #(
    parameter int DEPTH = 128,
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic        memread,
    input  logic        memwrite,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        fault
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0] cnt_load,
    output logic [15:0] cnt_store,
    output logic [15:0] cnt_fault
`endif
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0]       cnt;
    logic [31:0]      mem [DEPTH];
    // Words never stored to read back as their own index, which gives the power-up image without a RAM init pass.
    logic [DEPTH-1:0] written = '0;
    logic [AW+1:0]    a_q, ca;
    logic [31:0]      d_q, cd, cw, ld, sd, mw;
    logic [2:0]       f_q, cf;
    logic             w_q, cwr, acc, bad, noop, go, misal, illegal, oor;
    logic [AW-1:0]    idx;
    logic [3:0]       m;
    logic [7:0]       b;
    logic [15:0]      h;

    assign req_ready = state == IDLE;
    assign acc = req_valid & req_ready;
    assign noop = !memread & !memwrite;
    assign misal = (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & addr[1:0] != 2'b00);
    assign illegal = memwrite ? (funct3[2] | funct3[1:0] == 2'b11) : (funct3[1:0] == 2'b11 | funct3 == 3'b110);
    assign oor = {2'b00, addr[31:2]} >= 32'(DEPTH);
    assign bad = (memread & memwrite) | (!noop & (illegal | misal | oor));
    // In IDLE the access is driven straight from the inputs so LAT=0 completes on the accepting edge.
    assign ca = req_ready ? addr[AW+1:0] : a_q;
    assign cd = req_ready ? wdata : d_q;
    assign cf = req_ready ? funct3 : f_q;
    assign cwr = req_ready ? memwrite : w_q;
    assign go = req_ready ? (acc & !bad & !noop & LAT == 0) : (state == WAIT & cnt == '0);
    assign idx = ca[AW+1:2];
    assign cw = written[idx] ? mem[idx] : 32'(idx);
    assign b = 8'(cw >> {ca[1:0], 3'b000});
    assign h = 16'(cw >> {ca[1], 4'b0000});
    assign ld = cf[1] ? cw : cf[0] ? {{16{h[15] & !cf[2]}}, h} : {{24{b[7] & !cf[2]}}, b};
    assign m = cf[1] ? 4'hF : cf[0] ? (ca[1] ? 4'hC : 4'h3) : 4'b0001 << ca[1:0];
    assign sd = cf[1] ? cd : cf[0] ? {2{cd[15:0]}} : {4{cd[7:0]}};
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign mw[8*i +: 8] = m[i] ? sd[8*i +: 8] : cw[8*i +: 8];
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && acc) state_n = (bad || noop || LAT == 0) ? RESP : WAIT;
        if (state == WAIT && cnt == '0) state_n = RESP;
        if (state == RESP && resp_ready) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            resp_valid <= 1'b0;
            rdata <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            resp_valid <= state_n == RESP;
            cnt <= state == WAIT ? cnt - 4'd1 : cnt;
            if (acc) begin
                a_q <= addr[AW+1:0];
                d_q <= wdata;
                f_q <= funct3;
                w_q <= memwrite;
                cnt <= 4'(LAT - 1);
                rdata <= '0;
                fault <= bad;
            end
            if (go) rdata <= cwr ? '0 : ld;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && go && cwr) begin
            mem[idx] <= mw;
            written[idx] <= 1'b1;
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_load <= '0;
            cnt_store <= '0;
            cnt_fault <= '0;
        end else begin
            if (go && !cwr && cnt_load != '1) cnt_load <= cnt_load + 16'd1;
            if (go && cwr && cnt_store != '1) cnt_store <= cnt_store + 16'd1;
            if (acc && bad && cnt_fault != '1) cnt_fault <= cnt_fault + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests checked every cycle against a byte-level memory model.
module tb_load_store_unit;
    localparam int DEPTH = 128;
    localparam int LAT = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, memread = 1'b0, memwrite = 1'b0, resp_ready = 1'b0;
    logic        req_ready, resp_valid, fault;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [2:0]  funct3 = '0;
    int          errors = 0, checks = 0;
`ifdef LSU_PERF_CNT_EN
    logic [15:0] cnt_load, cnt_store, cnt_fault;
`endif

    load_store_unit #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata), .funct3(funct3), .memread(memread), .memwrite(memwrite),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .rdata(rdata), .fault(fault)
`ifdef LSU_PERF_CNT_EN
        , .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_fault(cnt_fault)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    bit          pending = 0, applied = 0, q_rd, q_wr, q_bad, exp_fault = 0;
    int          cyc = 0, due = 0;
    logic [31:0] q_addr, q_wdata, exp_rdata = '0;
    logic [2:0]  q_f3;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    function automatic bit is_bad(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        int size;
        if (rd && wr) return 1;
        if (!rd && !wr) return 0;
        if (wr ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        size = 1 << f3[1:0];
        if (a % size != 0) return 1;
        return (a / 4) >= DEPTH;
    endfunction

    function automatic void apply();
        int idx, off, size;
        logic [31:0] v, msk;
        exp_rdata = '0;
        exp_fault = q_bad;
        if (q_bad || (!q_rd && !q_wr)) return;
        idx = int'(q_addr / 4);
        off = int'(q_addr % 4);
        size = 1 << q_f3[1:0];
        msk = size == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        if (q_wr) begin
            for (int k = 0; k < size; k++) mem[idx][8*(off+k) +: 8] = q_wdata[8*k +: 8];
        end else begin
            v = (mem[idx] >> (8 * off)) & msk;
            if (!q_f3[2] && size < 4 && v[8*size-1]) v = v | ~msk;
            exp_rdata = v;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pending = 0;
        end else begin
            if (pending) begin
                if (cyc >= due && resp_ready) pending = 0;
            end else if (req_valid) begin
                pending = 1;
                applied = 0;
                q_rd = memread;
                q_wr = memwrite;
                q_f3 = funct3;
                q_addr = addr;
                q_wdata = wdata;
                q_bad = is_bad(memread, memwrite, funct3, addr);
                due = cyc + 1 + ((q_bad || (!memread && !memwrite)) ? 0 : LAT);
            end
            if (pending && !applied && cyc + 1 == due) begin
                apply();
                applied = 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        ev = pending && cyc >= due;
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        chk("req_ready", 32'(req_ready), 32'(!pending));
        if (ev) begin
            chk("rdata", rdata, exp_rdata);
            chk("fault", 32'(fault), 32'(exp_fault));
        end
    end

    task automatic txn(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] d, int hold,
                       bit lit, logic [31:0] er, bit ef, int elat);
        int k;
        @(negedge clk);
        req_valid = 1; memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = d;
        @(negedge clk);
        req_valid = 0; memread = 1'($urandom); memwrite = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        k = 0;
        while (!resp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!resp_valid) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout actual=0 required=1 at cycle %0d", cyc);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1);
        end
        if (lit) begin
            chk("lit_latency", 32'(k), 32'(elat));
            chk("lit_rdata", rdata, er);
            chk("lit_fault", 32'(fault), 32'(ef));
        end
        for (int j = 0; j < hold; j++) begin
            req_valid = 1; memread = 0; memwrite = 1; funct3 = 3'd2; addr = 32'h10; wdata = 32'hBAD0_BAD0;
            @(negedge clk);
        end
        req_valid = 0;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic rst_during_store(int gap);
        @(negedge clk);
        req_valid = 1; memread = 0; memwrite = 1; funct3 = 3'd2; addr = 32'h40; wdata = 32'h1234_5678;
        @(negedge clk);
        req_valid = 0;
        repeat (gap) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
    endtask

    initial begin
        int op, size;
        bit rd, wr;
        logic [2:0] f3;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) mem[i] = i;
        repeat (2) @(negedge clk);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        rst = 0;
        txn(1, 0, 3'd2, 32'h10, 0, 0, 1, 32'h0000_0004, 0, LAT);
        txn(0, 1, 3'd2, 32'h20, 32'hDEAD_BEEF, 0, 1, 32'h0, 0, LAT);
        txn(1, 0, 3'd2, 32'h20, 0, 0, 1, 32'hDEAD_BEEF, 0, LAT);
        txn(1, 0, 3'd0, 32'h23, 0, 0, 1, 32'hFFFF_FFDE, 0, LAT);
        txn(1, 0, 3'd4, 32'h23, 0, 0, 1, 32'h0000_00DE, 0, LAT);
        txn(1, 0, 3'd1, 32'h20, 0, 0, 1, 32'hFFFF_BEEF, 0, LAT);
        txn(1, 0, 3'd5, 32'h22, 0, 0, 1, 32'h0000_DEAD, 0, LAT);
        txn(0, 1, 3'd0, 32'h21, 32'h0000_0055, 0, 1, 32'h0, 0, LAT);
        txn(1, 0, 3'd2, 32'h20, 0, 0, 1, 32'hDEAD_55EF, 0, LAT);
        txn(1, 0, 3'd2, 32'h22, 0, 0, 1, 32'h0, 1, 0);
        txn(0, 1, 3'd1, 32'h203, 32'hFFFF_FFFF, 0, 1, 32'h0, 1, 0);
        txn(1, 0, 3'd3, 32'h20, 0, 0, 1, 32'h0, 1, 0);
        txn(1, 1, 3'd2, 32'h20, 32'h0, 0, 1, 32'h0, 1, 0);
        txn(1, 0, 3'd2, 32'h20, 0, 0, 1, 32'hDEAD_55EF, 0, LAT);
        txn(1, 0, 3'd2, 32'h10, 0, 3, 1, 32'h0000_0004, 0, LAT);
        txn(1, 0, 3'd2, 32'h10, 0, 0, 1, 32'h0000_0004, 0, LAT);
        txn(0, 0, 3'd7, 32'hFFFF_FFFF, 0, 0, 1, 32'h0, 0, 0);
        rst_during_store(0);
        txn(1, 0, 3'd2, 32'h40, 0, 0, 1, 32'h0000_0010, 0, LAT);
        rst_during_store(1);
        txn(1, 0, 3'd2, 32'h40, 0, 0, 1, 32'h0000_0010, 0, LAT);
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            rd = op == 0 || (op >= 2 && op <= 5);
            wr = op == 0 || op >= 6;
            f3 = 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) + (rd && !wr && $urandom_range(0, 1) ? 4 : 0) : $urandom_range(0, 7));
            a = $urandom_range(0, 4 * DEPTH + 63);
            if ($urandom_range(0, 19) == 0) a = $urandom;
            size = 1 << f3[1:0];
            if ($urandom_range(0, 9) < 7) a = a & ~32'(size - 1);
            txn(rd, wr, f3, a, $urandom, $urandom_range(0, 2), 0, 0, 0, 0);
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the RISC-V datapath: sits between execute (consumes ALU address, rs2 data, funct3, memread/memwrite) and writeback (produces load data).
- Owns the word-addressed data RAM and models a configurable access latency.
- Adds byte/halfword loads and stores, sign/zero extension, and fault detection.
- Uses valid/ready handshakes on both sides so the core can stall on memory.

Parameters:
- DEPTH, 128, number of 32-bit data words; valid word index is 0..DEPTH-1.
- LAT, 2, wait cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  unit can accept a request.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- funct3  in  3  access size/sign field of the instruction.
- memread  in  1  load request.
- memwrite  in  1  store request.
- resp_valid  out  1  response available to writeback.
- resp_ready  in  1  writeback consumes the response.
- rdata  out  32  extended load data; 0 for stores, faults and no-ops.
- fault  out  1  request was misaligned, out of range, or illegal.

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid=0; rdata=0; fault=0; wait counter=0.
- Reset does not clear the RAM. The RAM is initialised at time 0 with word i = i.
- FSM states are IDLE, WAIT and RESP.
- req_ready = (state==IDLE). A request is accepted on an edge where req_valid & req_ready. Request fields are registered on acceptance.
- Request classification, evaluated at the accepting edge:
  - Fault: memread&memwrite both 1.
  - Fault: illegal funct3. Loads accept 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores accept 000 sb, 001 sh, 010 sw.
  - Fault: misaligned, i.e. halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Fault: out of range, i.e. addr[31:2] >= DEPTH.
  - No-op: memread=memwrite=0.
- Fault or no-op requests: IDLE->RESP on the accepting edge; LAT is ignored. fault=1 for faults, 0 for no-ops; rdata=0. No RAM access.
- Valid load/store with LAT>0: IDLE->WAIT on the accepting edge, counter loaded with LAT-1.
  - WAIT decrements the counter each edge.
  - WAIT->RESP on the edge where counter==0.
  - With LAT=0: IDLE->RESP directly.
  - Net effect: resp_valid is first high LAT cycles after the cycle following acceptance.
- RAM access happens on the edge entering RESP, little-endian, word index addr[31:2]:
  - Loads: selected byte/half extended per funct3 (lb/lh sign-extend, lbu/lhu zero-extend) and registered into rdata.
  - Stores: only the addressed byte lanes are written (sb 1 lane, sh 2 lanes, sw 4 lanes); rdata=0.
- RESP holds resp_valid, rdata and fault stable until resp_valid&resp_ready.
  - On that edge: RESP->IDLE, resp_valid=0.
  - A new request is not accepted in the same cycle (req_ready=0 in RESP).
- Request inputs are ignored while req_ready=0.
- Reset mid-operation: reset has priority over every transition. A pending store is dropped with no RAM write, even if its write edge coincides with rst. The pending response is discarded.
- Stores and loads are strictly in order; there is only one outstanding request.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: adds outputs cnt_load, cnt_store, cnt_fault, each 16 bits.
  - Each counter increments on the edge entering RESP for a completed valid load, valid store, or fault respectively.
  - Counters saturate at 0xFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LAT=2, lw addr=0x10 -> accepted edge T; resp_valid high from the cycle after edge T+2; rdata=0x00000004; fault=0.
- sw wdata=0xDEADBEEF addr=0x20, then loads at the same word:
  - lw 0x20 -> 0xDEADBEEF
  - lb 0x23 -> 0xFFFFFFDE
  - lbu 0x23 -> 0x000000DE
  - lh 0x20 -> 0xFFFFBEEF
  - lhu 0x22 -> 0x0000DEAD
- sb wdata=0x00000055 addr=0x21 after the previous test, then lw 0x20 -> 0xDEAD55EF (other lanes untouched).
- Fault requests, each giving resp_valid the cycle after acceptance with fault=1, rdata=0 and RAM unchanged:
  - lw addr=0x22
  - sh addr=0x203 (out of range)
  - funct3=011 load
  - memread=memwrite=1
- resp_ready held low 3 cycles during a lw 0x10 response -> resp_valid, rdata=4 stable; req_ready=0; a concurrent request is ignored and is not executed later.
- sw wdata=0x12345678 addr=0x40, rst pulsed while in WAIT -> outputs return to reset values next cycle; a subsequent lw 0x40 returns 0x00000010.
